// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : isa_pkg
//  Description : Shared definitions for the 8-bit INST interface.
//                - Opcode encodings. The instruction layout is [7:4] opcode and
//                  [3:0] operand.
//                - HALT and bubble words.
//                - Sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package isa_pkg;

  // Opcode field encodings, instruction bits [7:4]
  localparam logic [3:0] OP_SYS       = 4'b0000;
  localparam logic [3:0] OP_LDI       = 4'b0001;
  localparam logic [3:0] OP_LDX       = 4'b0010;
  localparam logic [3:0] OP_STX       = 4'b0011;
  localparam logic [3:0] OP_ALU_FIRST = 4'b0100;
  localparam logic [3:0] OP_ALU_LAST  = 4'b1111;

  // HALT is consumed by the sequencer and is never issued. A bubble is
  // encoded as opcode 0000, which the decoder treats as a no-op.
  localparam logic [7:0] HALT_WORD   = 8'h00;
  localparam logic [7:0] BUBBLE_WORD = 8'h00;

  // Sequencer state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

endpackage
`default_nettype wire

// File: rtl/inst_mem.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem
//  Description : Program store with 2**ADDR_W words of INST_W bits each.
//                Writes are synchronous. Reads are asynchronous.
//                The contents have no reset, so they survive a reset.
//  Ports       : clk_i    - clock
//                we_i     - write enable, already qualified by the caller
//                waddr_i  - write address
//                wdata_i  - write data
//                raddr_i  - read address
//                rdata_o  - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_mem #(
  parameter int ADDR_W = 4,
  parameter int INST_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [INST_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [INST_W-1:0] rdata_o
);

  logic [INST_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/instruction_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_sequencer
//  Description : Issuing end of the INST interface.
//                - Holds a 16-word program and steps a program counter.
//                - Drives one registered instruction per clock to the decoder.
//                - HALT words (8'h00) are consumed and never issued.
//                - Stall cycles issue bubbles.
//  Config      : SEQ_WRAP_EN
//                  defined   - after the last address the PC wraps to 0 and
//                              execution continues. Only HALT or reset stops it.
//                  undefined - issuing the last address ends the program.
//  Ports       : clk_i        - clock
//                rst_i        - synchronous active-high reset
//                start_i      - run from address 0 (sampled in IDLE/HALTED)
//                stall_i      - hold PC and issue a bubble (RUN only)
//                we_i         - program write enable (IDLE/HALTED only)
//                waddr_i      - program write address
//                wdata_i      - program write data
//                inst_o       - registered instruction to the decoder
//                inst_valid_o - inst_o holds a real instruction
//                pc_o         - address of the next word to fetch
//                busy_o       - sequencer is in RUN
//                done_o       - sticky completion flag
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_sequencer
  import isa_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int INST_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [INST_W-1:0] wdata_i,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] PC_LAST = {ADDR_W{1'b1}};
  localparam logic [INST_W-1:0] HALT_W  = INST_W'(HALT_WORD);
  localparam logic [INST_W-1:0] BUBBLE  = INST_W'(BUBBLE_WORD);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [INST_W-1:0] rd_data;
  logic              mem_we;

  // The program may only change while the sequencer is not fetching from it.
  assign mem_we = we_i && (state_q != ST_RUN);

  inst_mem #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_inst_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (waddr_i),
    .wdata_i (wdata_i),
    .raddr_i (pc_q),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = BUBBLE;
    valid_d = 1'b0;
    done_d  = done_q;

    case (state_q)
      ST_RUN: begin
        // The stall check comes first, so a HALT sitting under a stall is
        // only recognised on the first unstalled cycle.
        if (stall_i) begin
          inst_d  = BUBBLE;
          valid_d = 1'b0;
        end else if (rd_data == HALT_W) begin
          state_d = ST_HALTED;
          done_d  = 1'b1;
        end else begin
          inst_d  = rd_data;
          valid_d = 1'b1;
`ifdef SEQ_WRAP_EN
          pc_d    = pc_q + 1'b1;
`else
          if (pc_q == PC_LAST) begin
            pc_d    = '0;
            state_d = ST_HALTED;
            done_d  = 1'b1;
          end else begin
            pc_d    = pc_q + 1'b1;
          end
`endif
        end
      end
      default: begin
        // IDLE and HALTED both wait for start_i.
        if (start_i) begin
          state_d = ST_RUN;
          pc_d    = '0;
          done_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      inst_q  <= BUBBLE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;
  assign pc_o         = pc_q;
  assign busy_o       = (state_q == ST_RUN);
  assign done_o       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_sequencer
//  Description : Bench for instruction_sequencer.
//                - Stimulus pushes the expected issued instructions into a
//                  scoreboard queue.
//                - Stimulus also pushes status comparisons into a check queue.
//                - The monitor evaluates both queues on the falling edge.
//                Honours SEQ_WRAP_EN for the end-of-program test.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_sequencer;

  bit         clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       stall_i = 1'b0;
  logic       we_i = 1'b0;
  logic [3:0] waddr_i = '0;
  logic [7:0] wdata_i = '0;
  logic [7:0] inst_o;
  logic       inst_valid_o;
  logic [3:0] pc_o;
  logic       busy_o;
  logic       done_o;

  instruction_sequencer #(.ADDR_W(4), .INST_W(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .stall_i      (stall_i),
    .we_i         (we_i),
    .waddr_i      (waddr_i),
    .wdata_i      (wdata_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .pc_o         (pc_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  logic [7:0] exp_q [$];
  chk_t       chk_q [$];
  int         checks = 0;
  int         errors = 0;
  int         issued = 0;
  int         base   = 0;

  // Monitor: every valid issue is compared against the scoreboard, then any
  // queued status comparisons are evaluated.
  always @(negedge clk) begin
    if (inst_valid_o === 1'b1) begin
      issued++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got %02h, required no issue", inst_o);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (inst_o !== e) begin
          errors++;
          $display("FAIL issue_data: got %02h, required %02h", inst_o, e);
        end
      end
    end
    while (chk_q.size() > 0) begin
      chk_t c;
      c = chk_q.pop_front();
      checks++;
      if (c.act !== c.exp) begin
        errors++;
        $display("FAIL %s: got %0h, required %0h", c.name, c.act, c.exp);
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    chk_t c;
    c.name = n;
    c.act  = a;
    c.exp  = e;
    chk_q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    we_i    = 1'b1;
    waddr_i = a;
    wdata_i = d;
    tick();
    we_i    = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string n, input int max);
    int cnt = 0;
    while (done_o !== 1'b1 && cnt < max) begin
      tick();
      cnt++;
    end
    chk(n, 32'(done_o), 32'd1);
  endtask

  // Lets the monitor consume the falling edge of the current cycle first.
  task automatic sync_mon();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // 1. Reset values
    tick();
    chk("rst_inst", 32'(inst_o), 32'h00);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_pc", 32'(pc_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    rst_i = 1'b0;

    // 2. Basic run to HALT, with two edges of latency from start to issue
    wr(4'd0, 8'h13);
    wr(4'd1, 8'h52);
    wr(4'd2, 8'h00);
    base = issued;
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h52);
    pulse_start();
    chk("t2_busy_after_start", 32'(busy_o), 32'd1);
    chk("t2_no_issue_yet", 32'(inst_valid_o), 32'd0);
    tick();
    chk("t2_first_inst", 32'(inst_o), 32'h13);
    chk("t2_first_valid", 32'(inst_valid_o), 32'd1);
    wait_done("t2_done_timeout", 20);
    chk("t2_halt_inst", 32'(inst_o), 32'h00);
    chk("t2_halt_valid", 32'(inst_valid_o), 32'd0);
    chk("t2_halt_busy", 32'(busy_o), 32'd0);
    chk("t2_halt_pc", 32'(pc_o), 32'd2);
    sync_mon();
    chk("t2_issue_count", 32'(issued - base), 32'd2);

    // 3. One stall cycle after the first issue
    base = issued;
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h52);
    pulse_start();
    chk("t3_done_cleared", 32'(done_o), 32'd0);
    tick();
    stall_i = 1'b1;
    tick();
    chk("t3_bubble_inst", 32'(inst_o), 32'h00);
    chk("t3_bubble_valid", 32'(inst_valid_o), 32'd0);
    chk("t3_pc_held", 32'(pc_o), 32'd1);
    stall_i = 1'b0;
    tick();
    chk("t3_resume_inst", 32'(inst_o), 32'h52);
    wait_done("t3_done_timeout", 20);
    chk("t3_halt_pc", 32'(pc_o), 32'd2);
    sync_mon();
    chk("t3_issue_count", 32'(issued - base), 32'd2);

    // 6. Write and start during RUN are ignored
    base = issued;
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h52);
    pulse_start();
    tick();
    we_i    = 1'b1;
    waddr_i = 4'd1;
    wdata_i = 8'hFF;
    start_i = 1'b1;
    tick();
    we_i    = 1'b0;
    start_i = 1'b0;
    chk("t6_no_restart_inst", 32'(inst_o), 32'h52);
    chk("t6_no_restart_pc", 32'(pc_o), 32'd2);
    wait_done("t6_done_timeout", 20);
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h52);
    pulse_start();
    wait_done("t6_rerun_timeout", 20);
    sync_mon();
    chk("t6_issue_count", 32'(issued - base), 32'd4);

    // Write and start on the same edge: the first fetch sees the new word
    base = issued;
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h52);
    we_i    = 1'b1;
    waddr_i = 4'd0;
    wdata_i = 8'h34;
    start_i = 1'b1;
    tick();
    we_i    = 1'b0;
    start_i = 1'b0;
    tick();
    chk("t7_new_word_inst", 32'(inst_o), 32'h34);
    wait_done("t7_done_timeout", 20);
    sync_mon();
    chk("t7_issue_count", 32'(issued - base), 32'd2);

    // 5. Reset in mid-run at PC=5, then rerun with the program intact
    for (int i = 0; i < 8; i++) wr(4'(i), 8'h21 + 8'(i));
    wr(4'd8, 8'h00);
    base = issued;
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h21 + 8'(i));
    pulse_start();
    repeat (5) tick();
    chk("t5_pc_before_rst", 32'(pc_o), 32'd5);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t5_rst_inst", 32'(inst_o), 32'h00);
    chk("t5_rst_valid", 32'(inst_valid_o), 32'd0);
    chk("t5_rst_pc", 32'(pc_o), 32'd0);
    chk("t5_rst_busy", 32'(busy_o), 32'd0);
    chk("t5_rst_done", 32'(done_o), 32'd0);
    sync_mon();
    chk("t5_partial_count", 32'(issued - base), 32'd5);
    base = issued;
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h21 + 8'(i));
    pulse_start();
    wait_done("t5_done_timeout", 30);
    chk("t5_halt_pc", 32'(pc_o), 32'd8);
    sync_mon();
    chk("t5_rerun_count", 32'(issued - base), 32'd8);

    // 4. Full program with no HALT word
    for (int i = 0; i < 16; i++) wr(4'(i), 8'h11);
    base = issued;
`ifdef SEQ_WRAP_EN
    for (int i = 0; i < 17; i++) exp_q.push_back(8'h11);
    pulse_start();
    repeat (17) tick();
    chk("t4_wrap_inst", 32'(inst_o), 32'h11);
    chk("t4_wrap_busy", 32'(busy_o), 32'd1);
    chk("t4_wrap_done", 32'(done_o), 32'd0);
    chk("t4_wrap_pc", 32'(pc_o), 32'd1);
    rst_i = 1'b1;
    sync_mon();
    chk("t4_wrap_count", 32'(issued - base), 32'd17);
    tick();
    rst_i = 1'b0;
`else
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h11);
    pulse_start();
    wait_done("t4_done_timeout", 40);
    chk("t4_end_pc", 32'(pc_o), 32'd0);
    chk("t4_end_busy", 32'(busy_o), 32'd0);
    sync_mon();
    chk("t4_end_count", 32'(issued - base), 32'd16);
`endif

    sync_mon();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    sync_mon();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
